// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: load/store funct3
// encodings, FSM state type and byte-strobe width.
package dmem_responder_pkg;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam int unsigned StrbW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F3Byte || f3 == F3Half || f3 == F3Word);
    return !(f3 == F3Byte || f3 == F3Half || f3 == F3Word ||
             f3 == F3ByteU || f3 == F3HalfU);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bus; master = core, slave = responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port DEPTH x 32 RAM with byte write enables; the read index is
// registered when en is high and the array is read combinationally from it.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [StrbW-1:0]         be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0]              mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (en) idx_d = idx;
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    for (int unsigned b = 0; b < StrbW; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx_q];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait states.
// `define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             issue;
  logic             sel_we;
  logic [2:0]       sel_f3;
  logic [31:0]      sel_addr, sel_wdata, sel_aligned;
  logic [StrbW-1:0] ram_be;
  logic [31:0]      ram_wdata, ram_rdata, rd_shift, rd_ext;
  logic [AW-1:0]    ram_idx;
  logic             rsp_err_c;

  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b01:   return {a[31:1], 1'b0};
      2'b10:   return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic e;
    e = funct3_illegal(we, f3) || ((a >> (AW + 2)) != 32'd0);
`ifdef DMEM_MISALIGN_ERR_EN
    e = e || (align_addr(f3, a) != a);
`endif
    return e;
  endfunction

  // With zero wait states the RAM access happens in the accept cycle, so it
  // must come straight from the bus rather than the not-yet-latched request.
  assign sel_we      = (state_q == IDLE) ? bus.req_we     : we_q;
  assign sel_f3      = (state_q == IDLE) ? bus.req_funct3 : f3_q;
  assign sel_addr    = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign sel_wdata   = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign sel_aligned = align_addr(sel_f3, sel_addr);
  assign ram_idx     = sel_aligned[AW+1:2];

  always_comb begin
    ram_be    = '0;
    ram_wdata = sel_wdata;
    case (sel_f3[1:0])
      2'b00: begin
        ram_be    = 4'b0001 << sel_aligned[1:0];
        ram_wdata = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        ram_be    = 4'b0011 << {sel_aligned[1], 1'b0};
        ram_wdata = {2{sel_wdata[15:0]}};
      end
      default: ram_be = '1;
    endcase
    if (!(issue && sel_we && !rst && !access_err(sel_we, sel_f3, sel_addr))) ram_be = '0;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    f3_d          = f3_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    issue         = 1'b0;
    bus.req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RESP;
            issue   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          issue   = 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (issue),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_shift = ram_rdata >> {sel_aligned[1:0], 3'b000};
    case (f3_q)
      F3Byte:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3ByteU: rd_ext = {24'd0, rd_shift[7:0]};
      F3Half:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3HalfU: rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign rsp_err_c     = access_err(we_q, f3_q, addr_q);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && rsp_err_c;
  assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !rsp_err_c) ? rd_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LATENCY=1 and LATENCY=0 instances,
// directed table, multi-cycle corner cases and randomized traffic vs a byte-level model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if b0();
  dmem_responder_if b1();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic        tv_valid [2];
  logic        tv_we    [2];
  logic [2:0]  tv_f3    [2];
  logic [31:0] tv_addr  [2];
  logic [31:0] tv_wdata [2];
  logic        tv_rrdy  [2];
  logic        o_rdy    [2];
  logic        o_rv     [2];
  logic [31:0] o_rd     [2];
  logic        o_err    [2];

  assign b0.req_valid  = tv_valid[0];
  assign b0.req_we     = tv_we[0];
  assign b0.req_funct3 = tv_f3[0];
  assign b0.req_addr   = tv_addr[0];
  assign b0.req_wdata  = tv_wdata[0];
  assign b0.rsp_ready  = tv_rrdy[0];
  assign b1.req_valid  = tv_valid[1];
  assign b1.req_we     = tv_we[1];
  assign b1.req_funct3 = tv_f3[1];
  assign b1.req_addr   = tv_addr[1];
  assign b1.req_wdata  = tv_wdata[1];
  assign b1.rsp_ready  = tv_rrdy[1];
  assign o_rdy[0] = b0.req_ready;
  assign o_rv[0]  = b0.rsp_valid;
  assign o_rd[0]  = b0.rsp_rdata;
  assign o_err[0] = b0.rsp_err;
  assign o_rdy[1] = b1.req_ready;
  assign o_rv[1]  = b1.rsp_valid;
  assign o_rd[1]  = b1.rsp_rdata;
  assign o_err[1] = b1.rsp_err;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Byte-addressed little-endian reference memory, one per DUT.
  logic [7:0] mb [2][NB];

  task automatic model(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
    int unsigned size;
    logic        legal;
    logic [31:0] a, v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    a     = addr - (addr % size);
    er    = !legal || (addr >= NB);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((addr % size) != 0) er = 1'b1;
`endif
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int unsigned i = 0; i < size; i++) mb[d][a + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int unsigned i = 0; i < size; i++) v = v | (32'(mb[d][a + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      input string name, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] erd;
    logic        eer;
    model(d, we, f3, addr, wd, erd, eer);
    @(negedge clk);
    n = 0;
    while (!o_rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " req_ready"}, 32'(o_rdy[d]), 32'd1);
    tv_valid[d] = 1'b1;
    tv_we[d]    = we;
    tv_f3[d]    = f3;
    tv_addr[d]  = addr;
    tv_wdata[d] = wd;
    @(negedge clk);
    tv_valid[d] = 1'b0;
    n = 1;
    while (!o_rv[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 32'(n), (d == 1) ? 32'd2 : 32'd1);
    rd = o_rd[d];
    er = o_err[d];
    chk({name, " rdata"}, rd, erd);
    chk({name, " err"}, 32'(er), 32'(eer));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, " hold rsp_valid"}, 32'(o_rv[d]), 32'd1);
      chk({name, " hold rdata"}, o_rd[d], rd);
      chk({name, " hold err"}, 32'(o_err[d]), 32'(er));
      chk({name, " hold req_ready"}, 32'(o_rdy[d]), 32'd0);
    end
    tv_rrdy[d] = 1'b1;
    @(negedge clk);
    tv_rrdy[d] = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tv_valid[d] = 1'b0; tv_we[d] = 1'b0; tv_f3[d] = '0;
      tv_addr[d] = '0; tv_wdata[d] = '0; tv_rrdy[d] = 1'b0;
    end

    // Directed vectors, LATENCY=1 instance.
    addv(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    addv(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    addv(1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    addv(1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    addv(1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    addv(1'b0, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
    addv(1'b1, 3'd0, 32'h11, 32'h55,       32'h0,        1'b0);
    addv(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    addv(1'b1, 3'd1, 32'h12, 32'h1234,     32'h0,        1'b0);
    addv(1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 1'b0);
    addv(1'b0, 3'd0, 32'h12, 32'h0,        32'h00000034, 1'b0);
    addv(1'b0, 3'd2, NB,     32'h0,        32'h0,        1'b1);
    addv(1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1);
    addv(1'b0, 3'd6, 32'h10, 32'h0,        32'h0,        1'b1);
    addv(1'b1, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1);
    addv(1'b1, 3'd0, NB,     32'hFF,       32'h0,        1'b1);
    addv(1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 1'b0);
    addv(1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0,        1'b0);
    addv(1'b1, 3'd1, 32'h22, 32'hFFFFABCD, 32'h0,        1'b0);
    addv(1'b0, 3'd2, 32'h20, 32'h0,        32'hABCD3344, 1'b0);
    addv(1'b1, 3'd0, 32'h23, 32'hAABBCC77, 32'h0,        1'b0);
    addv(1'b0, 3'd2, 32'h20, 32'h0,        32'h77CD3344, 1'b0);
    addv(1'b0, 3'd5, 32'h22, 32'h0,        32'h000077CD, 1'b0);
    addv(1'b0, 3'd4, 32'h21, 32'h0,        32'h00000033, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
    addv(1'b0, 3'd2, 32'h11, 32'h0,        32'h0,        1'b1);
    addv(1'b0, 3'd1, 32'h11, 32'h0,        32'h0,        1'b1);
`else
    addv(1'b0, 3'd2, 32'h11, 32'h0,        32'h123455EF, 1'b0);
    addv(1'b0, 3'd1, 32'h11, 32'h0,        32'h000055EF, 1'b0);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", 32'(o_rdy[d]), 32'd0);
      chk("reset rsp_valid", 32'(o_rv[d]), 32'd0);
      chk("reset rdata", o_rd[d], 32'd0);
      chk("reset err", 32'(o_err[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", 32'(o_rdy[1]), 32'd1);

    foreach (tbl[i]) begin
      xact(1, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d table rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d table err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Response back-pressure: outputs held for 5 cycles.
    xact(1, 1'b0, 3'd2, 32'h10, 32'h0, 5, "backpressure", rd, er);
    chk("backpressure data", rd, 32'h123455EF);

    // Reset while a store waits: the write must be dropped.
    @(negedge clk);
    tv_valid[1] = 1'b1; tv_we[1] = 1'b1; tv_f3[1] = 3'd2;
    tv_addr[1] = 32'h10; tv_wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    tv_valid[1] = 1'b0;
    chk("rst-in-wait rsp_valid before", 32'(o_rv[1]), 32'd0);
    chk("rst-in-wait req_ready before", 32'(o_rdy[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst-in-wait rsp_valid", 32'(o_rv[1]), 32'd0);
    chk("rst-in-wait rdata", o_rd[1], 32'd0);
    chk("rst-in-wait err", 32'(o_err[1]), 32'd0);
    chk("rst-in-wait req_ready", 32'(o_rdy[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-in-wait req_ready after", 32'(o_rdy[1]), 32'd1);
    xact(1, 1'b0, 3'd2, 32'h10, 32'h0, 0, "rst-in-wait readback", rd, er);
    chk("rst-in-wait word unchanged", rd, 32'h123455EF);

    // Zero-latency instance.
    xact(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "lat0 SW", rd, er);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 1, "lat0 LW", rd, er);
    chk("lat0 LW data", rd, 32'hDEADBEEF);

    // Fill both RAMs, then random traffic against the byte model.
    for (int unsigned w = 0; w < DEPTH; w++) begin
      for (int d = 0; d < 2; d++) xact(d, 1'b1, 3'd2, 32'(w * 4), $urandom, 0, "fill", rd, er);
    end
    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 2; d++) begin
        xact(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, NB + 15)), $urandom, $urandom_range(0, 2),
             $sformatf("rand%0d.%0d", i, d), rd, er);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one request at a time, from the load path (LB/LH/LW/LBU/LHU) or the store path (SB/SH/SW).
- Stores use byte strobes. Loads return sign- or zero-extended data after a configurable number of wait states.
- Sits between the core's execute stage and a word-addressed on-chip RAM.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two, at least 4.
- LATENCY, 1, wait states between request accept and response; range 0..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction funct3 (size and sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core can take the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault.

Behaviour:
- Reset: state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are preserved.
- Reset mid-operation abandons the access: a store whose RAM write has not yet been issued is dropped.
- FSM is IDLE -> WAIT -> RESP -> IDLE. WAIT is skipped when LATENCY=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata and load counter=LATENCY.
  - Next state is WAIT, or RESP when LATENCY=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 1 it moves to RESP.
  - The RAM read or write is issued in the final WAIT cycle (or the accept cycle when LATENCY=0).
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - A new request is never accepted in the RESP cycle itself.
- Timing: accept at cycle N gives rsp_valid at N+1+LATENCY.
- Store strobes (aligned access): RAM index = addr[log2(DEPTH)+1:2].
  - SB: strobe 4'b0001<<addr[1:0], wdata[7:0] replicated to all 4 bytes.
  - SH: strobe 4'b0011<<{addr[1],1'b0}, wdata[15:0] replicated to both halves.
  - SW: strobe 4'b1111.
- Load extraction: shift the word right by 8*addr[1:0], then:
  - LB: sign-extend bit 7.
  - LBU: zero-extend 8 bits.
  - LH: sign-extend bit 15.
  - LHU: zero-extend 16 bits.
  - LW: full word.
- Errors: rsp_err=1 and no RAM write on any of:
  - addr >= DEPTH*4 (out of range);
  - illegal funct3 (load 011/110/111; store >= 011).
- Error response carries rsp_rdata=0.
- A store response always has rsp_rdata=0.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, raise rsp_err=1 with no RAM effect.
- Undefined: the low address bits are cleared to natural alignment (addr[0] for halfwords, addr[1:0] for words). The access proceeds with no error.

Decomposition:
- Shared package:
  - load/store funct3 constants (F3Byte/F3Half/F3Word/F3ByteU/F3HalfU);
  - dmem_state_e {IDLE, WAIT, RESP};
  - the strobe-width constant.
  - OpILoad/OpSStore remain the opcode source.
- Natural sub-module: dmem_ram.
  - Single-port, DEPTH x 32, 4 byte write enables.
  - Synchronous write; combinational read-from-index register.
  - The responder owns all control and extension logic.

Test Plan:
- LATENCY=1. SW addr=0x10 data=0xDEADBEEF; then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB addr=0x11 data=0x55, then LW 0x10 -> 0xDEAD55EF; SH addr=0x12 data=0x1234, then LW -> 0x123455EF.
- LW addr=DEPTH*4 -> rsp_err=1, rsp_rdata=0. Load with funct3=011 -> rsp_err=1. The RAM word at 0x10 is unchanged.
- rsp_ready low for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout. Assert rst in WAIT during an SW -> next cycle rsp_valid=0; the target word is unchanged.
- LW addr=0x11:
  - with DMEM_MISALIGN_ERR_EN -> rsp_err=1;
  - without it -> data of word 0x10, rsp_err=0.
  - Also repeat the first scenario with LATENCY=0 -> rsp_valid 1 cycle after accept.
